field_sequencer: RTL and testbench
==================================

FIELD_SEQUENCER -- requirements
Module: field_sequencer

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 512, line width in bits (multiple of 8); LB = LINE_SIZE/8 bytes, OW = $clog2(LB)+1.
REQ-002 SHALL have ports clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-003 SHALL have line_valid in 1, line_ready out 1, line_in in LINE_SIZE; byte k = line_in[8k+7:8k].
REQ-004 SHALL have dec_window out 80, ten bytes at cursor little-endian (byte cursor in [7:0]), bytes past LB zero; dec_value in 64, dec_size in 5 from the external combinational varint_decoder.
REQ-005 SHALL have fld_valid out 1, fld_ready in 1, fld_id out 61, fld_type out 3, fld_offset out OW (payload start byte), fld_len out 32 (payload bytes).
REQ-006 SHALL have line_done out 1 (one-cycle pulse), err out 1 (one-cycle pulse), err_code out 2 (1 = bad wire type, 2 = header straddles line end).

Function
REQ-007 SHALL implement states IDLE, HDR, PAY, EMIT; line_ready = (state==IDLE).
REQ-008 IDLE, line accepted, skip_rem >= LB: skip_rem -= LB, pulse line_done, stay IDLE.
REQ-009 IDLE, line accepted, skip_rem < LB: cursor = skip_rem, skip_rem = 0, go HDR.
REQ-010 HDR (1 cycle): cursor == LB or decoded field_id == 0 -> pulse line_done, IDLE; cursor+dec_size > LB -> err, err_code=2, IDLE.
REQ-011 HDR otherwise: latch fld_id = dec_value[63:3], fld_type = dec_value[2:0], cursor += dec_size.
REQ-012 HDR next state: type 0 or 2 -> PAY; type 1 -> fld_len=8, EMIT; type 5 -> fld_len=4, EMIT; types 3,4,6,7 -> err, err_code=1, IDLE.
REQ-013 PAY (1 cycle): type 0 -> fld_len = dec_size, fld_offset = cursor; type 2 -> fld_len = dec_value[31:0], cursor += dec_size, fld_offset = cursor; go EMIT.
REQ-014 EMIT: fld_valid=1, all fld_* stable until fld_ready; handshake on fld_valid && fld_ready.
REQ-015 On handshake, nxt = fld_offset + fld_len (33-bit): nxt >= LB -> skip_rem = nxt - LB, pulse line_done, IDLE; else cursor = nxt, HDR.
REQ-016 err and line_done SHALL never assert in the same cycle; err discards remainder of line, clears skip_rem.
REQ-017 Minimum throughput: 2 cycles per fixed field, 3 per varint/LEN field when fld_ready held high.

Reset
REQ-018 rst SHALL force: state IDLE, cursor 0, skip_rem 0, fld_valid 0, fld_id 0, fld_type 0, fld_offset 0, fld_len 0, line_done 0, err 0, err_code 0.
REQ-019 rst mid-EMIT SHALL drop the pending field without handshake; first post-reset line begins at byte 0.

Configuration
REQ-020 With FIELD_FILTER_EN defined: ports filt_en in 1 and filt_id in 61 exist; when filt_en=1 and fld_id != filt_id, EMIT is bypassed and REQ-015 advance applies in the same cycle without fld_valid.
REQ-021 Without FIELD_FILTER_EN: ports absent, every field emitted.

Verification
REQ-022 Line bytes 08 96 01 then zeros -> one field id=1 type=0 offset=1 len=2; then line_done at byte 3 (id 0).
REQ-023 Bytes 12 05 xx xx xx xx xx 18 01 -> field id=2 type=2 offset=2 len=5, then id=3 type=0 offset=8 len=1.
REQ-024 Header 0A 80 01 at byte 60 -> id=1 len=128 offset=63; skip_rem=127; line 2 consumed whole (line_done, skip_rem=63); line 3 parsing starts at byte 63.
REQ-025 Byte 0x0B at 0 -> err pulse, err_code=1, no fld_valid, line_ready high next cycle.
REQ-026 fld_ready low 5 cycles during EMIT -> fld_* unchanged; rst asserted in EMIT -> fld_valid 0 immediately, state IDLE.
REQ-027 FIELD_FILTER_EN, filt_id=3, line of REQ-023 -> only id=3 emitted.

Source files
------------

// File: rtl/field_sequencer.sv
// Walks protobuf-style fields across a stream of fixed-width lines, emitting one descriptor per field.
// Optional FIELD_FILTER_EN adds filt_en/filt_id so that only fields matching filt_id are emitted.
module field_sequencer #(
   parameter  int unsigned LINE_SIZE = 512,
   localparam int unsigned LB        = LINE_SIZE / 8,
   localparam int unsigned OW        = $clog2(LB) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef FIELD_FILTER_EN
   input  logic                 filt_en,
   input  logic [60:0]          filt_id,
`endif
   input  logic                 line_valid,
   output logic                 line_ready,
   input  logic [LINE_SIZE-1:0] line_in,
   output logic [79:0]          dec_window,
   input  logic [63:0]          dec_value,
   input  logic [4:0]           dec_size,
   output logic                 fld_valid,
   input  logic                 fld_ready,
   output logic [60:0]          fld_id,
   output logic [2:0]           fld_type,
   output logic [OW-1:0]        fld_offset,
   output logic [31:0]          fld_len,
   output logic                 line_done,
   output logic                 err,
   output logic [1:0]           err_code
);

   localparam int unsigned SW = 33;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_PAY  = 2'd2;
   localparam logic [1:0] S_EMIT = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [OW-1:0]        cursor_q, cursor_d;
   logic [SW-1:0]        skip_rem_q, skip_rem_d;
   logic [LINE_SIZE-1:0] line_q, line_d;
   logic                 fld_valid_q, fld_valid_d;
   logic [60:0]          fld_id_q, fld_id_d;
   logic [2:0]           fld_type_q, fld_type_d;
   logic [OW-1:0]        fld_offset_q, fld_offset_d;
   logic [31:0]          fld_len_q, fld_len_d;
   logic                 line_done_q, line_done_d;
   logic                 err_q, err_d;
   logic [1:0]           err_code_q, err_code_d;

   logic [SW-1:0]        lb_w;
   logic [SW-1:0]        hdr_end;
   logic [SW-1:0]        adv;
   logic                 keep_c;
   logic [LINE_SIZE+79:0] win_ext;

   assign lb_w    = SW'(LB);
   assign hdr_end = SW'(cursor_q) + SW'(dec_size);
   assign adv     = SW'(fld_offset_q) + SW'(fld_len_q);

   // Window beyond the line end shifts in zeros.
   assign win_ext    = {80'd0, line_q} >> {cursor_q, 3'b000};
   assign dec_window = win_ext[79:0];

`ifdef FIELD_FILTER_EN
   logic [60:0] id_sel;
   assign id_sel = (state_q == S_HDR) ? dec_value[63:3] : fld_id_q;
   assign keep_c = !filt_en || (id_sel == filt_id);
`else
   assign keep_c = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      cursor_d     = cursor_q;
      skip_rem_d   = skip_rem_q;
      line_d       = line_q;
      fld_valid_d  = fld_valid_q;
      fld_id_d     = fld_id_q;
      fld_type_d   = fld_type_q;
      fld_offset_d = fld_offset_q;
      fld_len_d    = fld_len_q;
      line_done_d  = 1'b0;
      err_d        = 1'b0;
      err_code_d   = err_code_q;

      case (state_q)
         S_IDLE: begin
            if (line_valid) begin
               if (skip_rem_q >= lb_w) begin
                  skip_rem_d  = skip_rem_q - lb_w;
                  line_done_d = 1'b1;
               end else begin
                  cursor_d   = OW'(skip_rem_q);
                  skip_rem_d = '0;
                  line_d     = line_in;
                  state_d    = S_HDR;
               end
            end
         end
         S_HDR: begin
            if ((cursor_q == OW'(LB)) || (dec_value[63:3] == 61'd0)) begin
               line_done_d = 1'b1;
               state_d     = S_IDLE;
            end else if (hdr_end > lb_w) begin
               err_d      = 1'b1;
               err_code_d = 2'd2;
               skip_rem_d = '0;
               state_d    = S_IDLE;
            end else begin
               fld_id_d     = dec_value[63:3];
               fld_type_d   = dec_value[2:0];
               cursor_d     = OW'(hdr_end);
               fld_offset_d = OW'(hdr_end);
               case (dec_value[2:0])
                  3'd0, 3'd2: state_d = S_PAY;
                  3'd1: begin
                     fld_len_d   = 32'd8;
                     fld_valid_d = keep_c;
                     state_d     = S_EMIT;
                  end
                  3'd5: begin
                     fld_len_d   = 32'd4;
                     fld_valid_d = keep_c;
                     state_d     = S_EMIT;
                  end
                  default: begin
                     err_d      = 1'b1;
                     err_code_d = 2'd1;
                     skip_rem_d = '0;
                     state_d    = S_IDLE;
                  end
               endcase
            end
         end
         S_PAY: begin
            if (fld_type_q == 3'd0) begin
               fld_len_d    = 32'(dec_size);
               fld_offset_d = cursor_q;
            end else begin
               fld_len_d    = dec_value[31:0];
               cursor_d     = OW'(hdr_end);
               fld_offset_d = OW'(hdr_end);
            end
            fld_valid_d = keep_c;
            state_d     = S_EMIT;
         end
         default: begin
            // A filtered field arrives here with fld_valid low and advances at once.
            if (!fld_valid_q || fld_ready) begin
               fld_valid_d = 1'b0;
               if (adv >= lb_w) begin
                  skip_rem_d  = adv - lb_w;
                  line_done_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  cursor_d = OW'(adv);
                  state_d  = S_HDR;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cursor_q     <= '0;
         skip_rem_q   <= '0;
         line_q       <= '0;
         fld_valid_q  <= 1'b0;
         fld_id_q     <= '0;
         fld_type_q   <= '0;
         fld_offset_q <= '0;
         fld_len_q    <= '0;
         line_done_q  <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= '0;
      end else begin
         state_q      <= state_d;
         cursor_q     <= cursor_d;
         skip_rem_q   <= skip_rem_d;
         line_q       <= line_d;
         fld_valid_q  <= fld_valid_d;
         fld_id_q     <= fld_id_d;
         fld_type_q   <= fld_type_d;
         fld_offset_q <= fld_offset_d;
         fld_len_q    <= fld_len_d;
         line_done_q  <= line_done_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
      end
   end

   assign line_ready = (state_q == S_IDLE);
   assign fld_valid  = fld_valid_q;
   assign fld_id     = fld_id_q;
   assign fld_type   = fld_type_q;
   assign fld_offset = fld_offset_q;
   assign fld_len    = fld_len_q;
   assign line_done  = line_done_q;
   assign err        = err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_field_sequencer.sv
// Directed bench for field_sequencer with a behavioural varint decoder attached to dec_window.
module tb_field_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         line_valid;
   logic         line_ready;
   logic [511:0] line_in;
   logic [79:0]  dec_window;
   logic [63:0]  dec_value;
   logic [4:0]   dec_size;
   logic         fld_valid;
   logic         fld_ready;
   logic [60:0]  fld_id;
   logic [2:0]   fld_type;
   logic [6:0]   fld_offset;
   logic [31:0]  fld_len;
   logic         line_done;
   logic         err;
   logic [1:0]   err_code;
`ifdef FIELD_FILTER_EN
   logic         filt_en;
   logic [60:0]  filt_id;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [60:0] id;
      logic [2:0]  ty;
      logic [6:0]  off;
      logic [31:0] len;
   } fld_t;

   fld_t got[$];
   int   n_done = 0;
   int   n_err  = 0;
   int   n_both = 0;
   logic [1:0] last_code = 2'd0;

   logic [511:0] l22, l23, ln;

   field_sequencer dut (
      .clk(clk), .rst(rst),
`ifdef FIELD_FILTER_EN
      .filt_en(filt_en), .filt_id(filt_id),
`endif
      .line_valid(line_valid), .line_ready(line_ready), .line_in(line_in),
      .dec_window(dec_window), .dec_value(dec_value), .dec_size(dec_size),
      .fld_valid(fld_valid), .fld_ready(fld_ready), .fld_id(fld_id),
      .fld_type(fld_type), .fld_offset(fld_offset), .fld_len(fld_len),
      .line_done(line_done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // Reference varint decoder: LSB group first, stops at first byte with bit 7 clear.
   logic dec_stop;
   always_comb begin
      dec_value = '0;
      dec_size  = 5'd10;
      dec_stop  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!dec_stop) begin
            dec_value = dec_value | (64'(dec_window[8*i +: 7]) << (7*i));
            if (!dec_window[8*i+7]) begin
               dec_size = 5'(i + 1);
               dec_stop = 1'b1;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (fld_valid && fld_ready) got.push_back({fld_id, fld_type, fld_offset, fld_len});
         if (line_done) n_done++;
         if (err) begin
            n_err++;
            last_code = err_code;
         end
         if (line_done && err) n_both++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic send_line(input logic [511:0] l);
      for (int i = 0; i < 100 && !line_ready; i++) tick(1);
      check("ready_wait", 64'(line_ready), 64'd1);
      line_valid = 1'b1;
      line_in    = l;
      tick(1);
      line_valid = 1'b0;
   endtask

   task automatic clear_log();
      got.delete();
      n_done = 0;
      n_err  = 0;
   endtask

   task automatic check_field(input int idx, input logic [60:0] id, input logic [2:0] ty,
                              input logic [6:0] off, input logic [31:0] len);
      check($sformatf("fld%0d_present", idx), 64'(got.size() > idx), 64'd1);
      if (got.size() > idx) begin
         check($sformatf("fld%0d_id", idx),  64'(got[idx].id),  64'(id));
         check($sformatf("fld%0d_ty", idx),  64'(got[idx].ty),  64'(ty));
         check($sformatf("fld%0d_off", idx), 64'(got[idx].off), 64'(off));
         check($sformatf("fld%0d_len", idx), 64'(got[idx].len), 64'(len));
      end
   endtask

   initial begin
      rst        = 1'b1;
      line_valid = 1'b0;
      line_in    = '0;
      fld_ready  = 1'b1;
`ifdef FIELD_FILTER_EN
      filt_en    = 1'b0;
      filt_id    = '0;
`endif
      l22 = '0; l22[7:0] = 8'h08; l22[15:8] = 8'h96; l22[23:16] = 8'h01;
      l23 = '0; l23[7:0] = 8'h12; l23[15:8] = 8'h05;
      l23[63:56] = 8'h18; l23[71:64] = 8'h01;

      // reset state
      tick(3);
      check("rst_line_ready", 64'(line_ready), 64'd1);
      check("rst_fld_valid",  64'(fld_valid),  64'd0);
      check("rst_fld_id",     64'(fld_id),     64'd0);
      check("rst_fld_type",   64'(fld_type),   64'd0);
      check("rst_fld_offset", 64'(fld_offset), 64'd0);
      check("rst_fld_len",    64'(fld_len),    64'd0);
      check("rst_line_done",  64'(line_done),  64'd0);
      check("rst_err",        64'(err),        64'd0);
      check("rst_err_code",   64'(err_code),   64'd0);
      check("rst_window",     64'(dec_window[63:0]), 64'd0);
      rst = 1'b0;
      tick(1);

      // single varint field, then id 0 ends the line; varint field takes 3 cycles
      clear_log();
      send_line(l22);
      tick(2);
      check("thru_var_valid", 64'(fld_valid), 64'd1);
      tick(12);
      check("l22_count", 64'(got.size()), 64'd1);
      check_field(0, 61'd1, 3'd0, 7'd1, 32'd2);
      check("l22_done", 64'(n_done), 64'd1);
      check("l22_err",  64'(n_err),  64'd0);

      // LEN field then varint field
      clear_log();
      send_line(l23);
      tick(15);
      check("l23_count", 64'(got.size()), 64'd2);
      check_field(0, 61'd2, 3'd2, 7'd2, 32'd5);
      check_field(1, 61'd3, 3'd0, 7'd8, 32'd1);
      check("l23_done", 64'(n_done), 64'd1);

      // bad wire type 3
      clear_log();
      ln = '0; ln[7:0] = 8'h0B;
      send_line(ln);
      tick(1);
      check("bw_err",        64'(err),        64'd1);
      check("bw_err_code",   64'(err_code),   64'd1);
      check("bw_line_ready", 64'(line_ready), 64'd1);
      check("bw_fld_valid",  64'(fld_valid),  64'd0);
      check("bw_line_done",  64'(line_done),  64'd0);
      tick(1);
      check("bw_err_pulse",  64'(err),        64'd0);
      check("bw_count",      64'(got.size()), 64'd0);

      // payload spilling over two following lines
      clear_log();
      ln = '0; ln[7:0] = 8'h0A; ln[15:8] = 8'h3A;
      ln[487:480] = 8'h0A; ln[495:488] = 8'h80; ln[503:496] = 8'h01;
      send_line(ln);
      tick(15);
      check("sp1_count", 64'(got.size()), 64'd2);
      check_field(0, 61'd1, 3'd2, 7'd2,  32'd58);
      check_field(1, 61'd1, 3'd2, 7'd63, 32'd128);
      check("sp1_done", 64'(n_done), 64'd1);
      clear_log();
      ln = '1;
      send_line(ln);
      check("sp2_line_done",  64'(line_done),  64'd1);
      check("sp2_line_ready", 64'(line_ready), 64'd1);
      tick(3);
      check("sp2_count", 64'(got.size()), 64'd0);
      clear_log();
      ln = '0; ln[7:0] = 8'h08; ln[511:504] = 8'h1D;
      send_line(ln);
      tick(1);
      check("thru_fix_valid", 64'(fld_valid), 64'd1);
      tick(10);
      check("sp3_count", 64'(got.size()), 64'd1);
      check_field(0, 61'd3, 3'd5, 7'd64, 32'd4);
      check("sp3_done", 64'(n_done), 64'd1);

      // header straddling the line end
      do_reset();
      clear_log();
      ln = '0; ln[7:0] = 8'h0A; ln[15:8] = 8'h3D; ln[511:504] = 8'h88;
      send_line(ln);
      tick(12);
      check("st_count", 64'(got.size()), 64'd1);
      check_field(0, 61'd1, 3'd2, 7'd2, 32'd61);
      check("st_err",  64'(n_err),     64'd1);
      check("st_code", 64'(last_code), 64'd2);
      check("st_done", 64'(n_done),    64'd0);

      // back-pressure during EMIT, then reset while a field is pending
      clear_log();
      fld_ready = 1'b0;
      send_line(l23);
      for (int i = 0; i < 20 && !fld_valid; i++) tick(1);
      check("bp_valid", 64'(fld_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("bp_hold_valid", 64'(fld_valid),  64'd1);
         check("bp_hold_id",    64'(fld_id),     64'd2);
         check("bp_hold_off",   64'(fld_offset), 64'd2);
         check("bp_hold_len",   64'(fld_len),    64'd5);
      end
      rst = 1'b1;
      #1;
      check("rst_emit_valid", 64'(fld_valid),  64'd0);
      check("rst_emit_ready", 64'(line_ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      fld_ready = 1'b1;
      clear_log();
      send_line(l22);
      tick(12);
      check("post_rst_count", 64'(got.size()), 64'd1);
      check_field(0, 61'd1, 3'd0, 7'd1, 32'd2);

`ifdef FIELD_FILTER_EN
      // only id 3 passes the filter
      clear_log();
      filt_en = 1'b1;
      filt_id = 61'd3;
      send_line(l23);
      tick(15);
      check("filt_count", 64'(got.size()), 64'd1);
      check_field(0, 61'd3, 3'd0, 7'd8, 32'd1);
      check("filt_done", 64'(n_done), 64'd1);
      filt_en = 1'b0;
`endif

      check("never_both", 64'(n_both), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
